// File: rtl/led_pattern_if.sv
// Key and LED signal bundle between the key front-end, led_pattern_ctrl and the pads.
// The duty signal exists only when LED_PWM_EN is defined.
interface led_pattern_if #(
  parameter int LED_N    = 10,
  parameter int PWM_BITS = 4
);
  logic                key_next;
  logic                key_speed;
`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] duty;
`endif
  logic [LED_N-1:0]    led_pin;
  logic [1:0]          mode;
  logic                tick;

`ifdef LED_PWM_EN
  modport master (output key_next, key_speed, duty, input led_pin, mode, tick);
  modport slave  (input key_next, key_speed, duty, output led_pin, mode, tick);
`else
  modport master (output key_next, key_speed, input led_pin, mode, tick);
  modport slave  (input key_next, key_speed, output led_pin, mode, tick);
`endif

  if (LED_N < 2) begin : g_bad_led_n
    $error("LED_N must be at least 2");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm_bits
    $error("PWM_BITS must be at least 1");
  end
endinterface

// File: rtl/led_pattern_ctrl.sv
// Key-controlled LED pattern sequencer: step divider with four speeds and a mode FSM.
// Optional macro LED_PWM_EN adds the duty input and PWM brightness gating of led_pin.
module led_pattern_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int STEP_MS  = 500,
  parameter int LED_N    = 10,
  parameter int PWM_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  led_pattern_if.slave  bus
);

  localparam logic [1:0] M_SHIFT = 2'd0;
  localparam logic [1:0] M_PING  = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_OFF   = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned DIV_BASE   = CLK_HZ / 1000 * STEP_MS;
  localparam logic [31:0] DIV_BASE_W = 32'(DIV_BASE);
  localparam logic [LED_N-1:0] PAT_ONE = {{(LED_N-1){1'b0}}, 1'b1};

  // The fastest speed divides by 8, so the base period must survive that shift.
  if (DIV_BASE < 8) begin : g_bad_div_base
    $error("CLK_HZ/1000*STEP_MS must be at least 8");
  end
  if (LED_N < 2) begin : g_bad_led_n
    $error("LED_N must be at least 2");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm_bits
    $error("PWM_BITS must be at least 1");
  end

  logic [1:0]       mode_q;
  logic [1:0]       mode_d;
  logic [1:0]       speed_q;
  logic [31:0]      cnt_q;
  logic [31:0]      div;
  logic             cnt_wrap;
  logic             tick_q;
  logic [LED_N-1:0] pat_q;
  logic [LED_N-1:0] pat_init;
  logic [LED_N-1:0] pat_step;
  logic             dir_q;
  logic             dir_step;

  function automatic logic [LED_N-1:0] rotate_left(input logic [LED_N-1:0] p);
    return {p[LED_N-2:0], p[LED_N-1]};
  endfunction

  function automatic logic [LED_N-1:0] shift_dir(input logic [LED_N-1:0] p,
                                                 input logic             d);
    return (d == DIR_LEFT) ? (p << 1) : (p >> 1);
  endfunction

  // Step divider
  always_comb begin
    div      = DIV_BASE_W >> speed_q;
    cnt_wrap = (cnt_q == div - 32'd1);
  end

  // Either key restarts the period; a wrap in that same cycle produces no tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= 2'd0;
      cnt_q   <= 32'd0;
      tick_q  <= 1'b0;
    end else begin
      if (bus.key_speed) begin
        speed_q <= speed_q + 2'd1;
      end
      if (bus.key_speed || bus.key_next) begin
        cnt_q  <= 32'd0;
        tick_q <= 1'b0;
      end else if (cnt_wrap) begin
        cnt_q  <= 32'd0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 32'd1;
        tick_q <= 1'b0;
      end
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_SHIFT;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode FSM: next state
  always_comb begin
    mode_d = mode_q;
    if (bus.key_next) begin
      mode_d = mode_q + 2'd1;
    end
  end

  // Mode FSM: outputs (entry pattern for the next mode, step for the current one)
  always_comb begin
    pat_init = '0;
    pat_step = pat_q;
    dir_step = dir_q;

    case (mode_d)
      M_SHIFT: pat_init = PAT_ONE;
      M_PING:  pat_init = PAT_ONE;
      M_BLINK: pat_init = '1;
      default: pat_init = '0;
    endcase

    case (mode_q)
      M_SHIFT: pat_step = rotate_left(pat_q);
      M_PING: begin
        // Turning at an end moves one place back, so the end LED is lit once.
        if (dir_q == DIR_LEFT && pat_q[LED_N-1]) begin
          dir_step = DIR_RIGHT;
          pat_step = pat_q >> 1;
        end else if (dir_q == DIR_RIGHT && pat_q[0]) begin
          dir_step = DIR_LEFT;
          pat_step = pat_q << 1;
        end else begin
          pat_step = shift_dir(pat_q, dir_q);
        end
      end
      M_BLINK: pat_step = ~pat_q;
      default: pat_step = '0;
    endcase
  end

  // Pattern register: a mode change overrides a coincident step
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PAT_ONE;
      dir_q <= DIR_LEFT;
    end else if (bus.key_next) begin
      pat_q <= pat_init;
      dir_q <= DIR_LEFT;
    end else if (tick_q) begin
      pat_q <= pat_step;
      dir_q <= dir_step;
    end
  end

  assign bus.mode = mode_q;
  assign bus.tick = tick_q;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign bus.led_pin = pat_q & {LED_N{pwm_cnt < bus.duty}};
`else
  assign bus.led_pin = pat_q;
`endif

endmodule
